// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared fetch-stage types and constants
package instruction_fetch_unit_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
  localparam int BUF_ENTRIES = 2;
  typedef enum logic [1:0] {S_REQ, S_IDLE, S_WAIT, S_DROP} fetch_state_e;
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/instruction_fetch_unit_buffer.sv
// fetch_buffer: 2-entry FIFO of {pc4, instr}; flush empties it in one cycle
module fetch_buffer
  import instruction_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic [1:0]  count
);
  logic [1:0][63:0] mem;
  logic rd, wr, do_pop, do_push;
  assign do_pop = pop && count != 2'd0;
  assign do_push = push && (count != 2'(BUF_ENTRIES) || do_pop);
  assign dout = mem[rd];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) mem[wr] <= din;
      wr <= wr ^ do_push;
      rd <= rd ^ do_pop;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner issuing req/gnt fetches into a 2-entry buffer
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int BUF_DEPTH = BUF_ENTRIES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);
  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);
  fetch_state_e state, state_n;
  logic [31:0] fetch_pc;
  logic [63:0] head;
  logic [1:0] count;
  logic [2:0] occ;
  logic pop, push, room, room_after;
  assign valid_out = count != 2'd0;
  assign pop = valid_out && !freeze && !branch_taken;
  assign occ = {1'b0, count} - {2'b0, pop};
  assign room = occ < DEPTH;
  assign room_after = occ + 3'd1 < DEPTH;
  // in S_WAIT fetch_pc already equals the outstanding address + 4
  assign push = state == S_WAIT && imem_rvalid && !branch_taken;
  assign imem_addr = fetch_pc;
  assign pc_out = valid_out ? head[63:32] : 32'h0;
  assign instruction_out = valid_out ? head[31:0] : NOP_INSTR;
  always_comb begin
    imem_req = 1'b0;
    state_n = state;
    case (state)
      S_REQ: begin
        imem_req = room;
        state_n = imem_req && imem_gnt ? S_WAIT : room ? S_REQ : S_IDLE;
      end
      S_IDLE: state_n = room ? S_REQ : S_IDLE;
      S_WAIT: begin
        imem_req = imem_rvalid && room_after;
        state_n = !imem_rvalid || (imem_req && imem_gnt) ? S_WAIT : room_after ? S_REQ : S_IDLE;
      end
      S_DROP: state_n = imem_rvalid ? S_REQ : S_DROP;
      default: state_n = S_REQ;
    endcase
    // a redirect must still swallow any response that is or becomes outstanding
    if (branch_taken)
      state_n = (imem_req && imem_gnt) || ((state == S_WAIT || state == S_DROP) && !imem_rvalid) ? S_DROP : S_REQ;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_n;
      fetch_pc <= branch_taken ? align_word(branch_addr) : imem_req && imem_gnt ? fetch_pc + 32'd4 : fetch_pc;
    end
  end
  fetch_buffer u_buf (
    .clk(clk),
    .rst(rst),
    .flush(branch_taken),
    .push(push),
    .pop(pop),
    .din({fetch_pc, imem_rdata}),
    .dout(head),
    .count(count)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed fetch scenarios with a scoreboard of expected {pc4, instr}
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic rst, freeze, branch_taken, imem_req, imem_gnt, imem_rvalid, valid_out;
  logic [31:0] branch_addr, imem_addr, imem_rdata, pc_out, instruction_out;
  logic gnt_en, pend, found;
  logic [31:0] paddr, exp_addr;
  logic [63:0] hv;
  int lat, wait_cnt, passed = 0, total = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .pc_out(pc_out), .instruction_out(instruction_out), .valid_out(valid_out)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_gnt = gnt_en;
  assign imem_rvalid = pend && wait_cnt == 0;
  assign imem_rdata = imem_rvalid ? mem_word(paddr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst) pend <= 1'b0;
    else begin
      if (imem_rvalid) pend <= 1'b0;
      else if (pend) wait_cnt <= wait_cnt - 1;
      if (imem_req && imem_gnt) begin
        pend <= 1'b1;
        paddr <= imem_addr;
        wait_cnt <= lat - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic top_up();
    while (sb.size() < 4) begin
      sb.push_back({exp_addr + 32'd4, mem_word(exp_addr)});
      exp_addr += 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] a);
    sb.delete();
    exp_addr = a;
    top_up();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    top_up();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid_out && n < 30) begin
      step();
      n++;
    end
    chk(tag, 32'(valid_out), 32'd1);
  endtask

  task automatic find_wait(input string tag);
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      step();
      found = pend && !imem_rvalid && !imem_req;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // every accepted pop must match the next expected entry, in order
  always @(negedge clk) begin
    if (!rst && valid_out && !freeze && !branch_taken) begin
      logic [63:0] e;
      e = sb.size() != 0 ? sb.pop_front() : '1;
      chk("mon_pc4", pc_out, e[63:32]);
      chk("mon_instr", instruction_out, e[31:0]);
    end
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    gnt_en = 1'b1; lat = 1; exp_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd1);
    rst = 1'b0;
    restart_stream(32'h0);
    step();
    chk("t1_valid_c1", 32'(valid_out), 32'd0);
    chk("t1_addr_c1", imem_addr, 32'h4);
    chk("t1_req_c1", 32'(imem_req), 32'd1);
    step();
    chk("t1_valid_c2", 32'(valid_out), 32'd1);
    chk("t1_pc_c2", pc_out, 32'h4);
    chk("t1_instr_c2", instruction_out, mem_word(32'h0));
    repeat (6) step();
    chk("t1_streaming", 32'(valid_out), 32'd1);

    freeze = 1'b1;
    hv = sb[0];
    for (int i = 0; i < 5; i++) begin
      chk("t2_head_pc", pc_out, hv[63:32]);
      chk("t2_head_instr", instruction_out, hv[31:0]);
      step();
    end
    chk("t2_req_dropped", 32'(imem_req), 32'd0);
    chk("t2_still_valid", 32'(valid_out), 32'd1);
    freeze = 1'b0;
    repeat (6) step();

    lat = 3;
    find_wait("t3_find_wait");
    branch_taken = 1'b1;
    branch_addr = 32'h100;
    restart_stream(32'h100);
    step();
    branch_taken = 1'b0;
    chk("t3_drop_req", 32'(imem_req), 32'd0);
    chk("t3_flushed", 32'(valid_out), 32'd0);
    wait_valid("t3_valid");
    chk("t3_pc", pc_out, 32'h104);
    chk("t3_instr", instruction_out, mem_word(32'h100));

    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      step();
      found = imem_rvalid;
    end
    chk("t4_find_rvalid", 32'(found), 32'd1);
    branch_taken = 1'b1;
    branch_addr = 32'h100;
    gnt_en = 1'b0;
    restart_stream(32'h100);
    step();
    branch_taken = 1'b0;
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h100);
    chk("t4_valid", 32'(valid_out), 32'd0);

    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_req_held", 32'(imem_req), 32'd1);
      chk("t5_addr_held", imem_addr, 32'h100);
    end
    branch_taken = 1'b1;
    branch_addr = 32'h203;
    restart_stream(32'h200);
    step();
    branch_taken = 1'b0;
    chk("t5_redirect_addr", imem_addr, 32'h200);
    chk("t5_redirect_req", 32'(imem_req), 32'd1);
    gnt_en = 1'b1;
    lat = 1;
    wait_valid("t5_valid");
    chk("t5_pc", pc_out, 32'h204);
    chk("t5_instr", instruction_out, mem_word(32'h200));
    repeat (3) step();

    lat = 3;
    find_wait("t6_find_wait");
    rst = 1'b1;
    step();
    chk("t6_valid", 32'(valid_out), 32'd0);
    chk("t6_pc", pc_out, 32'h0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_req", 32'(imem_req), 32'd1);
    rst = 1'b0;
    lat = 1;
    restart_stream(32'h0);
    wait_valid("t6_resume_valid");
    chk("t6_resume_pc", pc_out, 32'h4);
    chk("t6_resume_instr", instruction_out, mem_word(32'h0));
    repeat (3) step();

    branch_taken = 1'b1;
    branch_addr = 32'hFFFF_FFF8;
    restart_stream(32'hFFFF_FFF8);
    step();
    branch_taken = 1'b0;
    wait_valid("t7_valid");
    chk("t7_pc", pc_out, 32'hFFFF_FFFC);
    repeat (6) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
